// File: rtl/hdmi_packet_pkg.sv
// Shared widths, constants and the packet container used by the data-island
// packet scheduler.
package hdmi_packet_pkg;

    localparam int PACKET_HEADER_W = 24;
    localparam int SUBPACKET_W     = 56;
    localparam int NUM_SUBPACKETS  = 4;

    localparam logic [4:0] SLOT_LAST = 5'd31;

    localparam logic [PACKET_HEADER_W-1:0] NULL_HEADER = 24'h000000;

    typedef struct packed {
        logic [PACKET_HEADER_W-1:0]                   header;
        logic [NUM_SUBPACKETS-1:0][SUBPACKET_W-1:0]   sub;
    } packet_t;

    localparam packet_t NULL_PACKET = '{header: NULL_HEADER, sub: '0};

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer and
// wrapping upward; the pointer moves past the winner on an advance strobe.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             hit;

    // Two passes: first indices at or above the pointer, then the wrapped lower ones.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        grant_o = '0;
        hit     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!hit && req_i[i] && (i >= int'(ptr_q))) begin
                grant_o[i] = 1'b1;
                hit        = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!hit && req_i[i]) begin
                grant_o[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            for (int i = 0; i < N; i++) begin
                if (grant_o[i]) begin
                    ptr_d = (i == N - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/packet_scheduler.sv
// Chooses the next data-island packet (index 0 strict priority, round-robin for the
// rest), holds it stable for a full 32-cycle slot, and falls back to the null packet.
module packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                                                clk_pixel,
    input  logic                                                reset,
    input  logic                                                data_island_period,
    input  logic [NUM_REQ-1:0]                                  req,
    input  logic [NUM_REQ-1:0][PACKET_HEADER_W-1:0]             req_header,
    input  logic [NUM_REQ-1:0][NUM_SUBPACKETS-1:0][SUBPACKET_W-1:0] req_sub,
    output logic [NUM_REQ-1:0]                                  grant,
    output logic [PACKET_HEADER_W-1:0]                          header,
    output logic [NUM_SUBPACKETS-1:0][SUBPACKET_W-1:0]          sub,
    output logic                                                island_request
);

    logic [4:0]         slot_q;
    packet_t            pkt_q;
    packet_t            pkt_d;
    packet_t            sel_pkt;
    logic               pending_q;
    logic               pending_d;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] grant_d;
    logic [NUM_REQ-1:0] win;
    logic [NUM_REQ-2:0] rr_grant;
    logic               load;
    logic               rr_advance;

    // Inside an island the register only reloads at the last slot cycle; outside it
    // reloads whenever nothing is waiting, so a pending packet is never replaced.
    assign load       = data_island_period ? (slot_q == SLOT_LAST) : !pending_q;
    assign rr_advance = load && !req[0] && (|rr_grant);

    rr_arbiter #(
        .N (NUM_REQ - 1)
    ) u_rr_arbiter (
        .clk       (clk_pixel),
        .rst       (reset),
        .req_i     (req[NUM_REQ-1:1]),
        .advance_i (rr_advance),
        .grant_o   (rr_grant)
    );

    always_comb begin
        win = '0;
        if (req[0]) begin
            win[0] = 1'b1;
        end else begin
            win[NUM_REQ-1:1] = rr_grant;
        end
    end

    always_comb begin
        sel_pkt = NULL_PACKET;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                sel_pkt.header = req_header[i];
                sel_pkt.sub    = req_sub[i];
            end
        end
    end

    always_comb begin
        pkt_d     = pkt_q;
        pending_d = pending_q;
        grant_d   = '0;
        if (load) begin
            if (|req) begin
                pkt_d     = sel_pkt;
                grant_d   = win;
                pending_d = 1'b1;
            end else begin
                pkt_d     = NULL_PACKET;
                pending_d = 1'b0;
            end
        end else if (data_island_period && (slot_q == 5'd0)) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            slot_q    <= 5'd0;
            pkt_q     <= NULL_PACKET;
            pending_q <= 1'b0;
            grant_q   <= '0;
        end else begin
            if (data_island_period) begin
                slot_q <= slot_q + 5'd1;
            end
            pkt_q     <= pkt_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
        end
    end

    assign grant          = grant_q;
    assign header         = pkt_q.header;
    assign sub            = pkt_q.sub;
    assign island_request = pending_q | (|req);

endmodule
